// File: rtl/delay_timer.sv
// Multi-channel delay/period timer: each channel counts 0..P and emits a
// one-cycle registered pulse on expiry, one-shot or auto-reloading.

module delay_timer_ch #(
  parameter int CBITS     = 16,
  parameter int N_DEFAULT = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_wr,
  input  logic [CBITS-1:0] i_period,
  input  logic             i_periodic,
  output logic             o_sig,
  output logic             o_busy
);
  localparam logic [0:0]       S_IDLE = 1'b0;
  localparam logic [0:0]       S_RUN  = 1'b1;
  localparam logic [CBITS-1:0] P_RST  = CBITS'(N_DEFAULT);

  logic [0:0]       r_state;
  logic [CBITS-1:0] r_cfg_p, r_act_p, r_cnt;
  logic             r_cfg_m, r_act_m, r_sig;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cfg_p <= P_RST;
      r_cfg_m <= 1'b0;
      r_act_p <= P_RST;
      r_act_m <= 1'b0;
      r_cnt   <= '0;
      r_sig   <= 1'b0;
    end else begin
      // Loads below read the pre-write config, so a write coincident with
      // start/reload takes effect only at the following load.
      if (i_wr) begin
        r_cfg_p <= i_period;
        r_cfg_m <= i_periodic;
      end
      r_sig <= 1'b0;
      if (i_stop) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else if (i_start) begin
        r_state <= S_RUN;
        r_cnt   <= '0;
        r_act_p <= r_cfg_p;
        r_act_m <= r_cfg_m;
      end else if (r_state == S_RUN) begin
        if (r_cnt == r_act_p) begin
          r_sig <= 1'b1;
          r_cnt <= '0;
          if (r_act_m) begin
            r_act_p <= r_cfg_p;
            r_act_m <= r_cfg_m;
          end else begin
            r_state <= S_IDLE;
          end
        end else begin
          r_cnt <= r_cnt + CBITS'(1);
        end
      end
    end
  end

  assign o_sig  = r_sig;
  assign o_busy = (r_state == S_RUN);
endmodule

module delay_timer #(
  parameter int NCH       = 4,
  parameter int CBITS     = 16,
  parameter int N_DEFAULT = 50000,
  parameter int CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [CBITS-1:0] cfg_period,
  input  logic             cfg_periodic,
  input  logic [NCH-1:0]   start,
  input  logic [NCH-1:0]   stop,
  input  logic             err_clr,
  output logic [NCH-1:0]   sig,
  output logic [NCH-1:0]   busy,
  output logic             err,
  output logic [CHW-1:0]   err_ch
);
  localparam logic [CHW:0] NCH_W = NCH[CHW:0];

  logic           w_bad;
  logic [NCH-1:0] w_wr;
  logic           r_err;
  logic [CHW-1:0] r_err_ch;

  assign w_bad = cfg_we & ((cfg_period == '0) | ({1'b0, cfg_ch} >= NCH_W));

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign w_wr[i] = cfg_we & ~w_bad & (cfg_ch == CHW'(i));
    delay_timer_ch #(.CBITS(CBITS), .N_DEFAULT(N_DEFAULT)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_start   (start[i]),
      .i_stop    (stop[i]),
      .i_wr      (w_wr[i]),
      .i_period  (cfg_period),
      .i_periodic(cfg_periodic),
      .o_sig     (sig[i]),
      .o_busy    (busy[i])
    );
  end

  // A rejected write beats err_clr; err_ch keeps the first offender until cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err    <= 1'b0;
      r_err_ch <= '0;
    end else if (w_bad) begin
      r_err <= 1'b1;
      if (!r_err || err_clr) r_err_ch <= cfg_ch;
    end else if (err_clr) begin
      r_err    <= 1'b0;
      r_err_ch <= '0;
    end
  end

  assign err    = r_err;
  assign err_ch = r_err_ch;
endmodule

// File: tb/tb_delay_timer.sv
// Directed bench for delay_timer plus a randomised phase with invariant monitors.

module tb_delay_timer;
  localparam int NCH = 4, CBITS = 16, CHW = 2;

  logic             clk = 1'b0;
  logic             rst, cfg_we, cfg_periodic, err_clr, err;
  logic [CHW-1:0]   cfg_ch, err_ch;
  logic [CBITS-1:0] cfg_period;
  logic [NCH-1:0]   start, stop, sig, busy;

  int n_tests = 0, n_fail = 0;
  int viol_cnt = 0, viol_sig2 = 0, viol_err = 0;

  delay_timer #(.NCH(NCH), .CBITS(CBITS), .N_DEFAULT(50000)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_periodic(cfg_periodic),
    .start(start), .stop(stop), .err_clr(err_clr),
    .sig(sig), .busy(busy), .err(err), .err_ch(err_ch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [CHW-1:0] ch, input logic [CBITS-1:0] p, input logic m);
    cfg_we = 1'b1; cfg_ch = ch; cfg_period = p; cfg_periodic = m;
    tick();
    cfg_we = 1'b0;
  endtask

  // Invariant monitors
  logic [NCH-1:0] w_cnt_bad;
  for (genvar g = 0; g < NCH; g++) begin : g_mon
    assign w_cnt_bad[g] = dut.g_ch[g].u_ch.r_cnt > dut.g_ch[g].u_ch.r_act_p;
  end

  logic [NCH-1:0] m_sig_prev = '0;
  logic           m_err_prev = 1'b0, m_bad = 1'b0;
  always @(posedge clk) begin
    m_sig_prev <= sig;
    m_err_prev <= err;
    m_bad      <= cfg_we && (cfg_period == '0);
  end
  always @(negedge clk) begin
    if (|w_cnt_bad) viol_cnt <= viol_cnt + 1;
    if (|(sig & m_sig_prev)) viol_sig2 <= viol_sig2 + 1;
    if (err && !m_err_prev && !m_bad) viol_err <= viol_err + 1;
  end

  initial begin
    int n;
    logic hit;
    rst = 1'b1; cfg_we = 0; cfg_ch = 0; cfg_period = 0; cfg_periodic = 0;
    start = 0; stop = 0; err_clr = 0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_sig", sig, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_err_ch", err_ch, 0);

    // ch0 P=3 periodic: pulses every 4 cycles
    wr(0, 3, 1);
    start[0] = 1; tick(); start[0] = 0;
    chk("p3_busy0", busy[0], 1);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("p3_sig_k%0d", k), sig[0], (k % 4 == 0));
      chk($sformatf("p3_busy_k%0d", k), busy[0], 1);
    end
    stop[0] = 1; tick(); stop[0] = 0;
    chk("p3_stop_busy", busy[0], 0);

    // default config one-shot on ch1
    start[1] = 1; tick(); start[1] = 0;
    n = 0;
    do begin tick(); n++; end while (!sig[1] && n < 50010);
    chk("def_latency", n, 50001);
    chk("def_busy_fall", busy[1], 0);
    hit = 0;
    for (int k = 0; k < 6; k++) begin tick(); hit |= sig[1] | busy[1]; end
    chk("def_no_more", hit, 0);

    // ch2 P=10 periodic, rewrite to P=2 mid-count
    wr(2, 10, 1);
    start[2] = 1; tick(); start[2] = 0;
    for (int k = 1; k <= 17; k++) begin
      if (k == 6) begin cfg_we = 1; cfg_ch = 2; cfg_period = 2; cfg_periodic = 1; end
      tick();
      cfg_we = 0;
      chk($sformatf("rw_sig_k%0d", k), sig[2], (k == 11 || k == 14 || k == 17));
    end
    stop[2] = 1; tick(); stop[2] = 0;

    // stop beats start; retrigger at cnt==P suppresses the pulse
    start[0] = 1; tick(); start[0] = 0;
    tick(); tick();
    start[0] = 1; stop[0] = 1; tick(); start[0] = 0; stop[0] = 0;
    chk("ss_busy", busy[0], 0);
    chk("ss_sig", sig[0], 0);
    hit = 0;
    for (int k = 0; k < 6; k++) begin tick(); hit |= sig[0]; end
    chk("ss_idle_nosig", hit, 0);
    start[0] = 1; tick(); start[0] = 0;
    tick(); tick(); tick();
    start[0] = 1; tick(); start[0] = 0;
    chk("rt_sig", sig[0], 0);
    chk("rt_busy", busy[0], 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("rt_sig_k%0d", k), sig[0], (k == 4));
    end
    stop[0] = 1; tick(); stop[0] = 0;

    // config errors
    wr(3, 5, 0);
    wr(3, 0, 1);
    chk("e_err", err, 1);
    chk("e_err_ch", err_ch, 3);
    start[3] = 1; tick(); start[3] = 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("e_cfg_keep_k%0d", k), sig[3], (k == 6));
    end
    chk("e_oneshot_idle", busy[3], 0);
    wr(1, 0, 0);
    chk("e_err_ch_sticky", err_ch, 3);
    err_clr = 1; tick(); err_clr = 0;
    chk("e_clr_err", err, 0);
    chk("e_clr_err_ch", err_ch, 0);
    err_clr = 1; wr(2, 0, 0); err_clr = 0;
    chk("e_clr_race_err", err, 1);
    chk("e_clr_race_ch", err_ch, 2);
    err_clr = 1; tick(); err_clr = 0;
    chk("e_clr2", err, 0);

    // write coincident with start uses old config
    cfg_we = 1; cfg_ch = 3; cfg_period = 2; cfg_periodic = 0; start[3] = 1;
    tick(); cfg_we = 0; start[3] = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("ws_old_k%0d", k), sig[3], (k == 6));
    end
    start[3] = 1; tick(); start[3] = 0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("ws_new_k%0d", k), sig[3], (k == 3));
    end

    // random phase
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NCH; i++) begin
        start[i] = ($urandom_range(0, 15) == 0);
        stop[i]  = ($urandom_range(0, 31) == 0);
      end
      cfg_we       = ($urandom_range(0, 3) == 0);
      cfg_ch       = CHW'($urandom_range(0, 3));
      cfg_period   = CBITS'($urandom_range(0, 7));
      cfg_periodic = 1'($urandom_range(0, 1));
      err_clr      = ($urandom_range(0, 15) == 0);
      tick();
    end
    start = 0; stop = 0; cfg_we = 0; err_clr = 0;

    // reset mid-count, with a rejected write on the same edge
    for (int i = 0; i < NCH; i++) wr(CHW'(i), 7, 1);
    start = '1; tick(); start = '0;
    tick(); tick(); tick();
    rst = 1; cfg_we = 1; cfg_period = 0; start = '1;
    tick();
    rst = 0; cfg_we = 0; start = '0;
    chk("mr_sig", sig, 0);
    chk("mr_busy", busy, 0);
    chk("mr_err", err, 0);
    chk("mr_err_ch", err_ch, 0);
    hit = 0;
    for (int k = 0; k < 10; k++) begin tick(); hit |= |sig; end
    chk("mr_no_sig", hit, 0);

    tick();
    chk("inv_cnt_le_p", viol_cnt, 0);
    chk("inv_sig_2row", viol_sig2, 0);
    chk("inv_err_rise", viol_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/delay_timer.md
DELAY_TIMER -- requirements
Module: delay_timer

Interface
REQ-001 Parameter NCH, default 4, number of independent timer channels (1..16).
REQ-002 Parameter CBITS, default 16, counter and period width.
REQ-003 Parameter N_DEFAULT, default 50000, reset period of every channel; SHALL be in 1..2^CBITS-1.
REQ-004 Parameter CHW, default max(1,$clog2(NCH)), channel-select width.
REQ-005 clk  in  1  single clock; all state SHALL update on posedge clk only.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 cfg_we  in  1  config write strobe.
REQ-008 cfg_ch  in  CHW  channel targeted by the write.
REQ-009 cfg_period  in  CBITS  new period P.
REQ-010 cfg_periodic  in  1  new mode: 1 = periodic, 0 = one-shot.
REQ-011 start  in  NCH  per-channel start/retrigger, level-sampled each edge.
REQ-012 stop  in  NCH  per-channel abort.
REQ-013 err_clr  in  1  clears err.
REQ-014 sig  out  NCH  one-cycle expiry pulse per channel, registered.
REQ-015 busy  out  NCH  1 while the channel is in RUN.
REQ-016 err  out  1  sticky config-error flag.
REQ-017 err_ch  out  CHW  channel of the first rejected write since last clear.

Function
REQ-018 Each channel SHALL hold a config register (period, mode), an active register (period, mode) and a counter cnt[CBITS-1:0], and SHALL be in state IDLE or RUN.
REQ-019 IDLE + start: go to RUN, cnt=0, active <= config; busy=1 from the next cycle.
REQ-020 RUN, cnt < active period: cnt increments by 1 per edge; sig=0.
REQ-021 RUN, cnt == active period: sig=1 for exactly the next cycle; cnt=0; periodic -> stay RUN and reload active <= config; one-shot -> IDLE.
REQ-022 Latency: start sampled at edge t -> sig high during cycle t+P+1; periodic -> repeats every P+1 cycles.
REQ-023 RUN + start (retrigger): cnt=0, active <= config, no sig that edge even if cnt == active period.
REQ-024 stop: go to IDLE, cnt=0, sig=0 that edge; stop SHALL win over simultaneous start or expiry.
REQ-025 cfg_we with cfg_period >= 1 and cfg_ch < NCH: update the config register; a running channel SHALL keep its active values until the next reload or retrigger.
REQ-026 cfg_we with cfg_period == 0 or cfg_ch >= NCH: the write SHALL be rejected; config is unchanged; err=1 next cycle; err_ch is captured only if err was 0.
REQ-027 err_clr clears err and err_ch next cycle; a simultaneous rejected write SHALL win (err stays 1, err_ch = that channel).
REQ-028 cfg_we to channel c coincident with start[c]: the start SHALL use the old config; the new value applies from the next load.
REQ-029 In every channel and every cycle, cnt <= active period SHALL hold; the counter SHALL never wrap.
REQ-030 Channels SHALL be fully independent; simultaneous events on different channels SHALL not interact.

Reset
REQ-031 rst at an edge: all channels IDLE, cnt=0, config and active = (N_DEFAULT, one-shot), sig=0, busy=0, err=0, err_ch=0.
REQ-032 rst SHALL override all other inputs in the same cycle, including mid-count; no sig SHALL be emitted for an aborted count.

Verification
REQ-033 Reset, write ch0 P=3 periodic, pulse start[0] at edge t -> sig[0] high in cycles t+4, t+8, t+12; busy[0]=1 throughout.
REQ-034 Default config, start[1] -> single sig[1] at t+50001; busy[1] falls with it; nothing further.
REQ-035 ch2 P=10 running, at cnt=5 write P=2 -> current expiry still at t+11; next period 3 cycles.
REQ-036 ch0 running, start[0] and stop[0] in the same cycle -> IDLE, no sig; start alone at cnt=P -> no sig, count restarts.
REQ-037 Write P=0 to ch3 -> err=1, err_ch=3, config unchanged; then a rejected write to ch1 -> err_ch stays 3; err_clr -> err=0.
REQ-038 Random stimulus with assertions: cnt <= active period always; sig is never high 2 cycles in a row when P >= 1; err never rises without a rejected write; rst mid-count -> outputs at reset values next cycle.
